// File: rtl/conditioner_pkg.sv
// Shared types and constants for the input conditioning front end.
package conditioner_pkg;

    // Per-button debounce FSM states
    typedef enum logic [1:0] {
        IDLE         = 2'd0,
        PRESS_WAIT   = 2'd1,
        PRESSED      = 2'd2,
        RELEASE_WAIT = 2'd3
    } btn_state_t;

    // Debounce window: short for simulation, long for a real board clock
    localparam int DEBOUNCE_COUNT_TB   = 32'sd4;
    localparam int DEBOUNCE_COUNT_FPGA = 32'sd500000;

    // Larger of two integers, used for counter sizing
    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    // Counter width able to hold the longer of the two windows without wrapping
    function automatic int cnt_width(input int deb, input int lng);
        return $clog2(max_int(deb, lng) + 32'sd1);
    endfunction

endpackage

// File: rtl/debounce_channel.sv
// Single-button conditioner: synchroniser, debounce FSM and press pulse.
// Optional long-press detection is built when LONG_PRESS_EN is defined.
module debounce_channel
    import conditioner_pkg::*;
#(
    parameter int SYNC_STAGES    = 2,
    parameter int DEBOUNCE_COUNT = DEBOUNCE_COUNT_TB,
    parameter int LONG_COUNT     = 16,
    parameter int CNT_W          = cnt_width(DEBOUNCE_COUNT, LONG_COUNT)
) (
    input  logic clk,
    input  logic rst,
    input  logic raw,
    output logic pulse,
    output logic level
`ifdef LONG_PRESS_EN
    ,
    output logic long_pulse
`endif
);

    localparam logic [CNT_W-1:0] DEB_LAST = CNT_W'(DEBOUNCE_COUNT - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
`ifdef LONG_PRESS_EN
    localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_COUNT - 1);
`endif

    logic [SYNC_STAGES-1:0] sync_r;
    logic                   in_s;      // synchronised raw level, 0 = pressed
    btn_state_t             state_r, state_s;
    logic [CNT_W-1:0]       cnt_r, cnt_s;
    logic                   pulse_s, pulse_r, level_r;
`ifdef LONG_PRESS_EN
    logic                   long_s, long_r, done_s, done_r;
`endif

    // Counter step that sticks at all-ones instead of wrapping
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == CNT_MAX) ? v : v + CNT_W'(1);
    endfunction

    assign in_s = sync_r[SYNC_STAGES-1];

    // Synchroniser chain; resets to released so a held button still debounces after reset
    always_ff @(posedge clk) begin
        if (!rst) begin
            sync_r <= {SYNC_STAGES{1'b1}};
        end else begin
            sync_r <= {sync_r[SYNC_STAGES-2:0], raw};
        end
    end

    // Next-state, counter and pulse decode
    always_comb begin
        state_s = state_r;
        cnt_s   = cnt_r;
        pulse_s = 1'b0;
`ifdef LONG_PRESS_EN
        long_s  = 1'b0;
        done_s  = done_r;
`endif
        case (state_r)
            IDLE: begin
                cnt_s = '0;
`ifdef LONG_PRESS_EN
                done_s = 1'b0;
`endif
                if (!in_s) begin
                    state_s = PRESS_WAIT;
                end else begin
                    state_s = IDLE;
                end
            end
            PRESS_WAIT: begin
                if (in_s) begin
                    state_s = IDLE;
                    cnt_s   = '0;
                end else if (cnt_r == DEB_LAST) begin
                    state_s = PRESSED;
                    cnt_s   = '0;
                    pulse_s = 1'b1;
                end else begin
                    cnt_s = sat_inc(cnt_r);
                end
            end
            PRESSED: begin
                if (in_s) begin
                    state_s = RELEASE_WAIT;
                    cnt_s   = '0;
                end else begin
`ifdef LONG_PRESS_EN
                    // Counter measures hold time; the done flag blocks repeats until IDLE
                    cnt_s = sat_inc(cnt_r);
                    if ((cnt_r == LONG_LAST) && !done_r) begin
                        long_s = 1'b1;
                        done_s = 1'b1;
                    end else begin
                        long_s = 1'b0;
                    end
`else
                    cnt_s = '0;
`endif
                end
            end
            RELEASE_WAIT: begin
                if (!in_s) begin
                    state_s = PRESSED;
`ifdef LONG_PRESS_EN
                    // The sample that cancels the release is itself a held cycle
                    cnt_s = CNT_W'(1);
`else
                    cnt_s = '0;
`endif
                end else if (cnt_r == DEB_LAST) begin
                    state_s = IDLE;
                    cnt_s   = '0;
                end else begin
                    cnt_s = sat_inc(cnt_r);
                end
            end
            default: begin
                state_s = IDLE;
                cnt_s   = '0;
            end
        endcase
    end

    // State, counter and registered outputs
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_r <= IDLE;
            cnt_r   <= '0;
            pulse_r <= 1'b0;
            level_r <= 1'b0;
`ifdef LONG_PRESS_EN
            long_r  <= 1'b0;
            done_r  <= 1'b0;
`endif
        end else begin
            state_r <= state_s;
            cnt_r   <= cnt_s;
            pulse_r <= pulse_s;
            level_r <= (state_s == PRESSED) || (state_s == RELEASE_WAIT);
`ifdef LONG_PRESS_EN
            long_r  <= long_s;
            done_r  <= done_s;
`endif
        end
    end

    assign pulse = pulse_r;
    assign level = level_r;
`ifdef LONG_PRESS_EN
    assign long_pulse = long_r;
`endif

endmodule

// File: rtl/input_conditioner.sv
// Board input conditioner: debounced button pulses/levels and a filtered switch bank.
// Define LONG_PRESS_EN to add the button_long output and long-press detection.
module input_conditioner
    import conditioner_pkg::*;
#(
    parameter int NUM_BUTTONS    = 3,
    parameter int SWITCH_LEN     = 15,
    parameter int SYNC_STAGES    = 2,
    parameter int DEBOUNCE_COUNT = DEBOUNCE_COUNT_TB,
    parameter int LONG_COUNT     = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NUM_BUTTONS-1:0] button_raw,
    input  logic [SWITCH_LEN-1:0]  switch_raw,
    output logic [NUM_BUTTONS-1:0] button_pulse,
    output logic [NUM_BUTTONS-1:0] button_level,
    output logic [SWITCH_LEN-1:0]  switch_out,
    output logic                   switch_changed
`ifdef LONG_PRESS_EN
    ,
    output logic [NUM_BUTTONS-1:0] button_long
`endif
);

    localparam int               CNT_W   = cnt_width(DEBOUNCE_COUNT, LONG_COUNT);
    localparam logic [CNT_W-1:0] SW_LAST = CNT_W'(DEBOUNCE_COUNT - 1);

    logic [SWITCH_LEN-1:0] sw_sync_r [SYNC_STAGES];
    logic [SWITCH_LEN-1:0] sw_in_s;
    logic [SWITCH_LEN-1:0] shadow_r;
    logic [SWITCH_LEN-1:0] switch_out_r;
    logic [CNT_W-1:0]      sw_cnt_r;
    logic                  changed_r;

    for (genvar g = 0; g < NUM_BUTTONS; g++) begin : gen_chan
        debounce_channel #(
            .SYNC_STAGES    (SYNC_STAGES),
            .DEBOUNCE_COUNT (DEBOUNCE_COUNT),
            .LONG_COUNT     (LONG_COUNT),
            .CNT_W          (CNT_W)
        ) u_chan (
            .clk        (clk),
            .rst        (rst),
            .raw        (button_raw[g]),
            .pulse      (button_pulse[g]),
            .level      (button_level[g])
`ifdef LONG_PRESS_EN
            ,
            .long_pulse (button_long[g])
`endif
        );
    end

    assign sw_in_s = sw_sync_r[SYNC_STAGES-1];

    // Switch synchroniser chains, cleared to 0 on reset
    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                sw_sync_r[i] <= '0;
            end
        end else begin
            sw_sync_r[0] <= switch_raw;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                sw_sync_r[i] <= sw_sync_r[i-1];
            end
        end
    end

    // Stability filter: any change restarts the window; a stable new value is published once
    always_ff @(posedge clk) begin
        if (!rst) begin
            shadow_r     <= '0;
            sw_cnt_r     <= '0;
            switch_out_r <= '0;
            changed_r    <= 1'b0;
        end else if (sw_in_s != shadow_r) begin
            shadow_r  <= sw_in_s;
            sw_cnt_r  <= '0;
            changed_r <= 1'b0;
        end else if (sw_cnt_r == SW_LAST) begin
            if (shadow_r != switch_out_r) begin
                switch_out_r <= shadow_r;
                changed_r    <= 1'b1;
            end else begin
                changed_r    <= 1'b0;
            end
        end else begin
            sw_cnt_r  <= sw_cnt_r + CNT_W'(1);
            changed_r <= 1'b0;
        end
    end

    assign switch_out     = switch_out_r;
    assign switch_changed = changed_r;

endmodule

// File: tb/tb_input_conditioner.sv
// Self-checking bench for input_conditioner: directed scenarios plus random
// button/switch activity compared each cycle against a run-length reference model.
module tb_input_conditioner;

    localparam int NB  = 3;
    localparam int SL  = 15;
    localparam int SS  = 2;
    localparam int DEB = 4;
    localparam int LNG = 16;

    logic          clk = 1'b0;
    logic          rst;
    logic [NB-1:0] button_raw;
    logic [SL-1:0] switch_raw;
    logic [NB-1:0] button_pulse;
    logic [NB-1:0] button_level;
    logic [SL-1:0] switch_out;
    logic          switch_changed;
`ifdef LONG_PRESS_EN
    logic [NB-1:0] button_long;
`endif

    input_conditioner #(
        .NUM_BUTTONS    (NB),
        .SWITCH_LEN     (SL),
        .SYNC_STAGES    (SS),
        .DEBOUNCE_COUNT (DEB),
        .LONG_COUNT     (LNG)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .button_raw     (button_raw),
        .switch_raw     (switch_raw),
        .button_pulse   (button_pulse),
        .button_level   (button_level),
        .switch_out     (switch_out),
        .switch_changed (switch_changed)
`ifdef LONG_PRESS_EN
        ,
        .button_long    (button_long)
`endif
    );

    always #5 clk = ~clk;

    int n_eval = 0;
    int n_fail = 0;

    // Reference model: inputs delayed SS edges, then a run length of samples that
    // disagree with the current debounced value; DEB+1 in a row flips it.
    logic [NB-1:0] m_bq [SS];
    logic [SL-1:0] m_sq [SS];
    logic [NB-1:0] m_level, m_pulse, m_long, m_done;
    int            m_run  [NB];
    int            m_held [NB];
    logic [SL-1:0] m_sw_prev, m_sw_out;
    int            m_sw_run;
    logic          m_sw_chg;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_eval++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_edge();
        logic [NB-1:0] bs;
        logic [SL-1:0] ss;
        logic          pressed;
        if (!rst) begin
            for (int i = 0; i < SS; i++) begin
                m_bq[i] = '1;
                m_sq[i] = '0;
            end
            m_level = '0; m_pulse = '0; m_long = '0; m_done = '0;
            for (int i = 0; i < NB; i++) begin
                m_run[i]  = 0;
                m_held[i] = 0;
            end
            m_sw_prev = '0; m_sw_out = '0; m_sw_run = 1; m_sw_chg = 1'b0;
        end else begin
            bs = m_bq[SS-1];
            ss = m_sq[SS-1];
            for (int i = SS-1; i > 0; i--) begin
                m_bq[i] = m_bq[i-1];
                m_sq[i] = m_sq[i-1];
            end
            m_bq[0] = button_raw;
            m_sq[0] = switch_raw;
            m_pulse = '0;
            m_long  = '0;
            for (int i = 0; i < NB; i++) begin
                pressed = ~bs[i];
                if (pressed == m_level[i]) m_run[i] = 0;
                else m_run[i]++;
                if (m_run[i] == DEB + 1) begin
                    m_level[i] = ~m_level[i];
                    m_run[i]   = 0;
                    if (m_level[i]) begin
                        m_pulse[i] = 1'b1;
                        m_held[i]  = 0;
                        m_done[i]  = 1'b0;
                    end
                end else if (m_level[i]) begin
                    if (pressed) m_held[i]++;
                    else m_held[i] = 0;
                    if (m_held[i] == LNG && !m_done[i]) begin
                        m_long[i] = 1'b1;
                        m_done[i] = 1'b1;
                    end
                end
            end
            if (ss != m_sw_prev) begin
                m_sw_prev = ss;
                m_sw_run  = 1;
            end else if (m_sw_run < 1000) begin
                m_sw_run++;
            end
            m_sw_chg = 1'b0;
            if (m_sw_run >= DEB + 1 && m_sw_prev != m_sw_out) begin
                m_sw_out = m_sw_prev;
                m_sw_chg = 1'b1;
            end
        end
    endtask

    task automatic compare_all();
        check("pulse", button_pulse, m_pulse);
        check("level", button_level, m_level);
        check("switch_out", switch_out, m_sw_out);
        check("switch_changed", switch_changed, m_sw_chg);
`ifdef LONG_PRESS_EN
        check("long", button_long, m_long);
`endif
    endtask

    // One clock: model follows the edge, outputs sampled 1 time unit later
    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        compare_all();
    endtask

    initial begin
        int first_at, cnt;
        int r;

        // Reset with all buttons held down
        rst = 1'b0; button_raw = 3'b000; switch_raw = 15'h0000;
        repeat (3) step();
        check("rst_pulse", button_pulse, 3'b000);
        check("rst_level", button_level, 3'b000);
        check("rst_switch", switch_out, 15'h0000);
        check("rst_changed", switch_changed, 1'b0);
        rst = 1'b1;
        for (int k = 0; k < 6; k++) begin
            step();
            check("rst_rel_early", button_pulse, 3'b000);
        end
        step();
        check("rst_rel_pulse", button_pulse, 3'b111);
        check("rst_rel_level", button_level, 3'b111);
        step();
        check("rst_rel_once", button_pulse, 3'b000);
        button_raw = 3'b111;
        repeat (12) step();
        check("rst_released", button_level, 3'b000);

        // Clean press on button 0, held 20 cycles
        button_raw[0] = 1'b0; first_at = -1; cnt = 0;
        for (int k = 0; k < 20; k++) begin
            step();
            if (button_pulse[0]) begin
                cnt++;
                if (first_at < 0) first_at = k;
            end
        end
        check("press_latency", 32'(first_at), 32'd6);
        check("press_pulse_count", 32'(cnt), 32'd1);
        check("press_level_held", button_level, 3'b001);
        button_raw[0] = 1'b1; first_at = -1;
        for (int k = 0; k < 12; k++) begin
            step();
            if (!button_level[0] && first_at < 0) first_at = k;
        end
        check("release_latency", 32'(first_at), 32'd6);

        // Bounce on button 1: two-cycle 0/1 toggles, then released
        cnt = 0;
        for (int k = 0; k < 18; k++) begin
            button_raw[1] = (k < 8) ? (((k / 2) % 2) != 0) : 1'b1;
            step();
            if (button_pulse[1] || button_level[1]) cnt++;
        end
        check("bounce_quiet", 32'(cnt), 32'd0);

        // Switch bank update and a short glitch
        switch_raw = 15'h0A5C; first_at = -1; cnt = 0;
        for (int k = 0; k < 10; k++) begin
            step();
            if (switch_changed) begin
                cnt++;
                if (first_at < 0) first_at = k;
            end
        end
        check("switch_latency", 32'(first_at), 32'd6);
        check("switch_change_count", 32'(cnt), 32'd1);
        check("switch_value", switch_out, 15'h0A5C);
        switch_raw = 15'h0A5D; cnt = 0;
        for (int k = 0; k < 13; k++) begin
            if (k == 3) switch_raw = 15'h0A5C;
            step();
            if (switch_changed) cnt++;
        end
        check("glitch_no_change", 32'(cnt), 32'd0);
        check("glitch_value", switch_out, 15'h0A5C);

        // Reset while button 2 is in its debounce window, button kept held
        button_raw[2] = 1'b0;
        repeat (4) step();
        rst = 1'b0;
        step();
        check("midrst_pulse", button_pulse, 3'b000);
        check("midrst_level", button_level, 3'b000);
        rst = 1'b1; first_at = -1; cnt = 0;
        for (int k = 0; k < 12; k++) begin
            step();
            if (button_pulse[2]) begin
                cnt++;
                if (first_at < 0) first_at = k;
            end
        end
        check("midrst_latency", 32'(first_at), 32'd6);
        check("midrst_pulse_count", 32'(cnt), 32'd1);
        button_raw[2] = 1'b1;
        repeat (12) step();

`ifdef LONG_PRESS_EN
        // Long press on button 2
        button_raw[2] = 1'b0; first_at = -1; cnt = 0;
        for (int k = 0; k < 40; k++) begin
            step();
            if (button_long[2]) begin
                cnt++;
                if (first_at < 0) first_at = k;
            end
        end
        check("long_latency", 32'(first_at), 32'd22);
        check("long_count", 32'(cnt), 32'd1);
        button_raw[2] = 1'b1;
        repeat (12) step();
`endif

        // Random activity against the reference model
        for (int c = 0; c < 800; c++) begin
            for (int i = 0; i < NB; i++) begin
                if ($urandom_range(0, 5) == 0) button_raw[i] = ~button_raw[i];
            end
            r = $urandom_range(0, 29);
            if (r == 0) switch_raw = 15'($urandom);
            else if (r == 1) switch_raw = switch_raw ^ (15'd1 << $urandom_range(0, 14));
            rst = ($urandom_range(0, 199) != 0);
            step();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_eval, n_fail);
        $finish;
    end

endmodule

// File: doc/input_conditioner.md
# input_conditioner

Front-end conditioning stage between the board's raw push-buttons/slide switches and `command_processor`. Synchronises every asynchronous input to `clk`, debounces the three active-low buttons into one-cycle press pulses, and filters the switch bank so the command path only sees stable values. It replaces the bare inverters on the button and switch pins.

## Interface
Parameters:
- `NUM_BUTTONS`, 3: button channels.
- `SWITCH_LEN`, 15: filtered switch bits; packing is {rw_switch2, rw_switch1, mode_switch, switch_array[11:0]}.
- `SYNC_STAGES`, 2: synchroniser flops per input; legal range 2–4.
- `DEBOUNCE_COUNT`, 4: consecutive stable cycles required. Use 4 for testbench; set per board clock on FPGA.
- `LONG_COUNT`, 16: extra held cycles before a long press. Used only with `LONG_PRESS_EN`.

Ports:
- `clk` in 1: system clock (scaled clock).
- `rst` in 1: synchronous, active-low reset.
- `button_raw` in NUM_BUTTONS: raw buttons, active-low (0 = pressed).
- `switch_raw` in SWITCH_LEN: raw switch bank.
- `button_pulse` out NUM_BUTTONS: one-cycle high per debounced press.
- `button_level` out NUM_BUTTONS: debounced pressed level, active-high.
- `switch_out` out SWITCH_LEN: debounced switch value.
- `switch_changed` out 1: one-cycle high when `switch_out` updates.
- `button_long` out NUM_BUTTONS: one-cycle high on long press. Present only with `LONG_PRESS_EN`.

## Operation
- Synchroniser reset values: button chains reset to 1 (released); switch chains reset to 0.
- Per-button FSM states: IDLE, PRESS_WAIT, PRESSED, RELEASE_WAIT.
  - IDLE → PRESS_WAIT when the synced input is 0; the counter clears.
  - PRESS_WAIT: the counter increments each cycle the input is 0. An input of 1 returns the FSM to IDLE and clears the counter. When the counter reaches DEBOUNCE_COUNT−1 with the input still 0, go to PRESSED and assert `button_pulse` that same cycle.
  - PRESSED → RELEASE_WAIT when the input is 1; the counter clears.
  - RELEASE_WAIT: counts cycles with input 1. An input of 0 returns the FSM to PRESSED with no new pulse. Reaching DEBOUNCE_COUNT−1 goes to IDLE.
- `button_level` = 1 in PRESSED and RELEASE_WAIT.
- Counter width is $clog2(max(DEBOUNCE_COUNT, LONG_COUNT)+1). The counter saturates and never wraps.
- Switch filter:
  - A shadow register holds the last synced vector. Any bit differing from the shadow reloads the shadow and clears the stability counter.
  - When the counter reaches DEBOUNCE_COUNT−1 and the shadow differs from `switch_out`, `switch_out` loads the shadow and `switch_changed` pulses.
  - Equal values never pulse.
- Channels are independent. Simultaneous presses produce simultaneous pulses.
- Reset mid-operation: all FSMs go to IDLE, counters to 0, all outputs to 0, with no pulse. A button still held after reset releases yields one pulse after full latency.

## Timing
- Reset values: `button_pulse`, `button_level`, `switch_out`, `switch_changed` and `button_long` are all 0.
- Press latency: the raw 0 is first sampled at edge 0. `button_pulse`/`button_level` rise after edge SYNC_STAGES+DEBOUNCE_COUNT (defaults: after edge 6).
- Release latency: `button_level` falls after edge SYNC_STAGES+DEBOUNCE_COUNT from the first sampled 1.
- Switch latency matches the press latency. `switch_out` and `switch_changed` update in the same cycle.
- A bounce shorter than DEBOUNCE_COUNT cycles (after sync) produces no output change.
- `button_pulse` is exactly one cycle wide regardless of hold time.

## Configuration
- `LONG_PRESS_EN` defined:
  - In PRESSED the counter keeps running. After DEBOUNCE_COUNT+LONG_COUNT total held cycles, `button_long` pulses once.
  - No repeat until the button returns to IDLE.
- `LONG_PRESS_EN` undefined: the `button_long` port and its logic are absent. The PRESSED counter stays idle.

## Structure
- Shared package `conditioner_pkg` holds:
  - the FSM state typedef (IDLE, PRESS_WAIT, PRESSED, RELEASE_WAIT), 2-bit;
  - default constants DEBOUNCE_COUNT_TB=4 and DEBOUNCE_COUNT_FPGA=500000.
- One sub-module, `debounce_channel`: synchroniser, FSM, counter and pulse/long logic for a single button. It is instantiated NUM_BUTTONS times with generate.
- The switch filter is inline in the top of this block.

## Test plan
All scenarios use default parameters.
- **Reset:** hold `rst`=0 for 3 cycles with `button_raw`=3'b000 → all outputs 0. Release reset → `button_pulse`=3'b111 for one cycle after edge 6.
- **Clean press:** `button_raw[0]` 1→0, held 20 cycles → `button_pulse[0]` high exactly one cycle after edge 6; `button_level[0]`=1 until 6 cycles after release.
- **Bounce:** `button_raw[1]` toggles 0/1/0/1 every 2 cycles, then stays 1 → no pulse, `button_level[1]` stays 0.
- **Switches:** `switch_raw` 0→15'h0A5C held → `switch_out`=15'h0A5C with `switch_changed` one cycle after edge 6. A 3-cycle glitch to 15'h0A5D → no change.
- **Mid-press reset:** assert `rst`=0 while the FSM is in PRESS_WAIT → no pulse; the FSM is in IDLE the next cycle.
- **Long press (LONG_PRESS_EN):** hold `button_raw[2]`=0 for 40 cycles → `button_long[2]` single pulse after edge 22, none afterwards.
